fsqrt_share_ctrl: RTL and testbench

//  Sequences one shared iterative 24-bit Newton square-root unit (start/busy/q interface) among NREQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Issues a one-cycle start to the unit and waits for it to finish.
//  - Returns the 32-bit result plus a sticky-rounded 24-bit result to the winning requester.
//  - Sits between the FP issue logic and the root unit.

---
 rtl/fsqrt_share_pkg.sv | 34 +++
 rtl/fsqrt_share_ctrl_if.sv | 38 +++
 rtl/fsqrt_share_ctrl_rr_pick.sv | 35 +++
 rtl/fsqrt_share_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fsqrt_share_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsqrt_share_pkg.sv
// Shared definitions for the square-root sharing controller.
//   OPW / QW : operand and raw-result widths of the root unit
//   state_e  : symbolic FSM encoding, used for the debug state view
//   IDLE..RESP : FSM state constants used by the controller flops
//   rnd24()  : sticky rounding of the 32-bit result down to 24 bits
package fsqrt_share_pkg;

    localparam int OPW = 24;
    localparam int QW  = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Any set bit below the kept field rounds up; an all-ones kept field
    // saturates instead of wrapping to zero.
    function automatic logic [OPW-1:0] rnd24(input logic [QW-1:0] q);
        logic [OPW-1:0] hi;
        hi = q[QW-1:QW-OPW];
        if (hi == {OPW{1'b1}}) begin
            return {OPW{1'b1}};
        end
        return hi + {{(OPW-1){1'b0}}, |q[QW-OPW-1:0]};
    endfunction

endpackage

// File: rtl/fsqrt_share_ctrl_if.sv
// Bundle of requester-side and root-unit-side signals of the controller.
//   slave  : controller view (takes requests, drives the root unit)
//   master : environment view (requesters, responders and the root unit)
// Handshake rules: a requester holds req_valid until it sees its req_ready
// bit; rsp_valid/rsp_q/rsp_q24/rsp_err stay stable until the matching
// rsp_ready bit is high on a clock edge. dbg_state mirrors the FSM.
interface fsqrt_share_ctrl_if import fsqrt_share_pkg::*; #(
    parameter int NREQ = 4
) ();

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_d;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [QW-1:0]       rsp_q;
    logic [OPW-1:0]      rsp_q24;
    logic                rsp_err;
    logic [OPW-1:0]      unit_d;
    logic                unit_start;
    logic                unit_ena;
    logic                unit_busy;
    logic [QW-1:0]       unit_q;
    state_e              dbg_state;

    modport slave (
        input  req_valid, req_d, rsp_ready, unit_busy, unit_q,
        output req_ready, rsp_valid, rsp_q, rsp_q24, rsp_err,
               unit_d, unit_start, unit_ena, dbg_state
    );

    modport master (
        output req_valid, req_d, rsp_ready, unit_busy, unit_q,
        input  req_ready, rsp_valid, rsp_q, rsp_q24, rsp_err,
               unit_d, unit_start, unit_ena, dbg_state
    );

endinterface

// File: rtl/fsqrt_share_ctrl_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this round
//   gnt : one-hot grant, id : encoded grant, any : some request present
module fsqrt_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] id,
    output logic                    any
);

    localparam int IDW = $clog2(NREQ);

    int idx;

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                id       = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fsqrt_share_ctrl.sv
// Shares one iterative 24-bit square-root unit among NREQ requesters.
// Round-robin pick in IDLE, one-cycle start in ISSUE, wait for the unit in
// RUN, hold the result for the winner in RESP.
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset; drops any in-flight operation
//   bus  : fsqrt_share_ctrl_if.slave (requests, responses, unit, dbg_state)
// Optional build macro FSQRT_SHARE_TIMEOUT_EN: abort RUN after TIMEOUT
// cycles of busy with rsp_err=1 and zero results; otherwise rsp_err is 0
// and RUN waits indefinitely.
module fsqrt_share_ctrl import fsqrt_share_pkg::*; #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               clrn,
    fsqrt_share_ctrl_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("fsqrt_share_ctrl: NREQ must be 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("fsqrt_share_ctrl: TIMEOUT must be at least 2");
    end

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [OPW-1:0] op_q, op_d;
    logic [QW-1:0]  q_q, q_d;
    logic [OPW-1:0] q24_q, q24_d;
    logic           first_q, first_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;

    fsqrt_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .id  (pick_id),
        .any (pick_any)
    );

`ifdef FSQRT_SHARE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        q_d     = q_q;
        q24_d   = q24_q;
        first_d = first_q;
`ifdef FSQRT_SHARE_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    id_d    = pick_id;
                    op_d    = bus.req_d[int'(pick_id)*OPW +: OPW];
                    state_d = ISSUE;
`ifdef FSQRT_SHARE_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                first_d = 1'b1;
                state_d = RUN;
`ifdef FSQRT_SHARE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            RUN: begin
                // busy is not yet valid in the first RUN cycle
                first_d = 1'b0;
`ifdef FSQRT_SHARE_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (!first_q && !bus.unit_busy) begin
                    q_d     = bus.unit_q;
                    q24_d   = rnd24(bus.unit_q);
                    state_d = RESP;
                end else if (bus.unit_busy && cnt_q == CW'(TIMEOUT - 1)) begin
                    // leaving RUN drops unit_ena, which aborts the unit
                    q_d     = '0;
                    q24_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`else
                if (!first_q && !bus.unit_busy) begin
                    q_d     = bus.unit_q;
                    q24_d   = rnd24(bus.unit_q);
                    state_d = RESP;
                end
`endif
            end
            default: begin
                if (bus.rsp_ready[id_q]) begin
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            q_q     <= '0;
            q24_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            q_q     <= q_d;
            q24_q   <= q24_d;
            first_q <= first_d;
        end
    end

`ifdef FSQRT_SHARE_TIMEOUT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready  = (state_q == IDLE) ? pick_gnt : '0;
    assign bus.rsp_valid  = (state_q == RESP) ? (NREQ'(1) << id_q) : '0;
    assign bus.rsp_q      = q_q;
    assign bus.rsp_q24    = q24_q;
    assign bus.unit_d     = op_q;
    assign bus.unit_start = (state_q == ISSUE);
    assign bus.unit_ena   = (state_q == ISSUE) || (state_q == RUN);
    assign bus.dbg_state  = state_e'(state_q);

endmodule

// File: tb/tb_fsqrt_share_ctrl.sv
module tb_fsqrt_share_ctrl;
  import fsqrt_share_pkg::*;

  logic clk;
  logic clrn;

  fsqrt_share_ctrl_if #(.NREQ(4)) bus ();

  fsqrt_share_ctrl #(.NREQ(4), .TIMEOUT(64)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural root unit stub ----------------
  // busy for 12 cycles starting the cycle after start, q = {d, stub_lo}
  logic        stub_busy;
  logic [4:0]  stub_cnt;
  logic [31:0] stub_q;
  logic [7:0]  stub_lo;
  logic        stub_stuck;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 5'd0;
      stub_q    <= 32'd0;
    end else if (bus.unit_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 5'd12;
      stub_q    <= {bus.unit_d, stub_lo};
    end else if (!bus.unit_ena) begin
      stub_busy <= 1'b0;
    end else if (stub_busy && !stub_stuck) begin
      if (stub_cnt == 5'd1) stub_busy <= 1'b0;
      stub_cnt <= stub_cnt - 5'd1;
    end
  end

  assign bus.unit_busy = stub_busy;
  assign bus.unit_q    = stub_q;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_pass;
  int n_total;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int id, input logic [23:0] d);
    bus.req_d[id*24 +: 24] = d;
  endtask

  // Runs one transaction for requester id whose request is already driven.
  task automatic txn(input int id, input logic [23:0] d, input logic [23:0] exp24,
                     input bit drop, input int stall);
    logic [3:0]  oh;
    logic [31:0] eq;
    int n;
    int starts;
    int bad_d;
    int bad_ena;
    int bad_stall;
    oh = 4'b0001 << id;
    #1;
    n = 0;
    while (bus.req_ready == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check("grant", 32'(bus.req_ready), 32'(oh));
    check("grant_onehot", $countones(bus.req_ready), 1);
    tick();
    if (drop) bus.req_valid[id] = 1'b0;
    n = 1;
    starts = 0;
    bad_d = 0;
    bad_ena = 0;
    while (bus.rsp_valid == 4'b0 && n < 100) begin
      if (bus.unit_start) starts++;
      if (bus.unit_d !== d) bad_d++;
      if (bus.unit_ena !== 1'b1) bad_ena++;
      tick();
      n++;
    end
    check("rsp_latency", n, 15);
    check("start_once", starts, 1);
    check("unit_d_held", bad_d, 0);
    check("unit_ena_run", bad_ena, 0);
    check("unit_ena_resp", 32'(bus.unit_ena), 0);
    eq = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdead_beef;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    check("rsp_q", bus.rsp_q, eq);
    check("rsp_q24", 32'(bus.rsp_q24), 32'(exp24));
    check("rsp_err", 32'(bus.rsp_err), 0);
    bad_stall = 0;
    for (int k = 0; k < stall; k++) begin
      tick();
      if (bus.rsp_valid !== oh || bus.rsp_q !== eq || bus.rsp_q24 !== exp24 ||
          bus.unit_start !== 1'b0 || bus.req_ready !== 4'b0) bad_stall++;
    end
    if (stall > 0) check("stall_hold", bad_stall, 0);
    bus.rsp_ready = oh;
    tick();
    bus.rsp_ready = 4'b0;
    check("rsp_release", 32'(bus.rsp_valid), 0);
    check("back_idle", 32'(bus.dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    n_pass = 0;
    n_total = 0;
    n_fail = 0;
    clrn = 1'b0;
    bus.req_valid = 4'b0;
    bus.req_d = '0;
    bus.rsp_ready = 4'b0;
    stub_lo = 8'h01;
    stub_stuck = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_q", bus.rsp_q, 0);
    check("rst_rsp_q24", 32'(bus.rsp_q24), 0);
    check("rst_unit_start", 32'(bus.unit_start), 0);
    check("rst_unit_ena", 32'(bus.unit_ena), 0);
    check("rst_unit_d", 32'(bus.unit_d), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    clrn = 1'b1;
    tick();

    // single request from requester 0
    set_d(0, 24'hfffe00);
    bus.req_valid = 4'b0001;
    exp_q.push_back(32'hfffe_0001);
    txn(0, 24'hfffe00, 24'hfffe01, 1'b1, 0);

    // rounding cases on requesters 1..3
    set_d(1, 24'h800000);
    bus.req_valid = 4'b0010;
    exp_q.push_back(32'h8000_0001);
    txn(1, 24'h800000, 24'h800001, 1'b1, 0);
    set_d(2, 24'hffffff);
    bus.req_valid = 4'b0100;
    exp_q.push_back(32'hffff_ff01);
    txn(2, 24'hffffff, 24'hffffff, 1'b1, 0);
    stub_lo = 8'h80;
    set_d(3, 24'h7fffff);
    bus.req_valid = 4'b1000;
    exp_q.push_back(32'h7fff_ff80);
    txn(3, 24'h7fffff, 24'h800000, 1'b1, 0);
    stub_lo = 8'h01;

    // all four held: order 0,1,2,3,0
    set_d(0, 24'h100000);
    set_d(1, 24'h200001);
    set_d(2, 24'h300002);
    set_d(3, 24'h400003);
    bus.req_valid = 4'b1111;
    exp_q.push_back(32'h1000_0001);
    txn(0, 24'h100000, 24'h100001, 1'b0, 0);
    exp_q.push_back(32'h2000_0101);
    txn(1, 24'h200001, 24'h200002, 1'b0, 0);
    exp_q.push_back(32'h3000_0201);
    txn(2, 24'h300002, 24'h300003, 1'b0, 0);
    exp_q.push_back(32'h4000_0301);
    txn(3, 24'h400003, 24'h400004, 1'b0, 0);
    exp_q.push_back(32'h1000_0001);
    txn(0, 24'h100000, 24'h100001, 1'b1, 0);

    // response stall with other requests pending
    exp_q.push_back(32'h2000_0101);
    txn(1, 24'h200001, 24'h200002, 1'b1, 10);
    exp_q.push_back(32'h3000_0201);
    txn(2, 24'h300002, 24'h300003, 1'b1, 0);
    exp_q.push_back(32'h4000_0301);
    txn(3, 24'h400003, 24'h400004, 1'b1, 0);

    // truncation case on requester 1 leaves ptr at 2
    stub_lo = 8'h00;
    set_d(1, 24'h123456);
    bus.req_valid = 4'b0010;
    exp_q.push_back(32'h1234_5600);
    txn(1, 24'h123456, 24'h123456, 1'b1, 0);
    stub_lo = 8'h01;

    // reset pulsed while requester 3 is in RUN
    bus.req_valid = 4'b1000;
    #1;
    check("pre_rst_grant", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0;
    tick();
    tick();
    check("pre_rst_run", 32'(bus.dbg_state), 32'(S_RUN));
    #2;
    clrn = 1'b0;
    #1;
    check("arst_unit_start", 32'(bus.unit_start), 0);
    check("arst_unit_ena", 32'(bus.unit_ena), 0);
    check("arst_unit_d", 32'(bus.unit_d), 0);
    check("arst_rsp_q", bus.rsp_q, 0);
    check("arst_rsp_q24", 32'(bus.rsp_q24), 0);
    check("arst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    tick();
    check("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    clrn = 1'b1;
    tick();
    check("post_rst_no_rsp", 32'(bus.rsp_valid), 0);
    set_d(1, 24'h0abcde);
    set_d(2, 24'h300002);
    bus.req_valid = 4'b0110;
    exp_q.push_back(32'h0abc_de01);
    txn(1, 24'h0abcde, 24'h0abcdf, 1'b1, 0);
    exp_q.push_back(32'h3000_0201);
    txn(2, 24'h300002, 24'h300003, 1'b1, 0);

`ifdef FSQRT_SHARE_TIMEOUT_EN
    // unit stuck busy: abort after 64 RUN cycles
    stub_stuck = 1'b1;
    set_d(3, 24'h555555);
    bus.req_valid = 4'b1000;
    #1;
    check("to_grant", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0;
    n = 1;
    while (bus.rsp_valid == 4'b0 && n < 200) begin
      tick();
      n++;
    end
    check("to_latency", n, 66);
    check("to_rsp_valid", 32'(bus.rsp_valid), 32'h8);
    check("to_rsp_err", 32'(bus.rsp_err), 1);
    check("to_rsp_q", bus.rsp_q, 0);
    check("to_rsp_q24", 32'(bus.rsp_q24), 0);
    check("to_unit_ena", 32'(bus.unit_ena), 0);
    stub_stuck = 1'b0;
    bus.rsp_ready = 4'b1000;
    tick();
    bus.rsp_ready = 4'b0;
    set_d(0, 24'h0000ff);
    bus.req_valid = 4'b0001;
    exp_q.push_back(32'h0000_ff01);
    txn(0, 24'h0000ff, 24'h000100, 1'b1, 0);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
